// File: rtl/batrider_pcm_arbiter.sv
// Two-channel PCM read arbiter in front of a single SDRAM read port.
// Each channel keeps a one-entry cache (tag/data/valid). A hit is answered
// combinationally. A miss is forwarded to the SDRAM port. When both channels
// miss at the same time, the arbiter alternates between them (round-robin).
//
// Ports:
//   CLK96, RESET96         clock and synchronous active-high reset
//   REQ0_CS/ADDR/OK/DOUT   OKI channel 0 request, address, data-valid, data
//   REQ1_CS/ADDR/OK/DOUT   OKI channel 1 request, address, data-valid, data
//   SD_CS/SD_ADDR          registered SDRAM read request and address
//   SD_OK/SD_DOUT          SDRAM data-valid and data
module batrider_pcm_arbiter #(
  parameter int unsigned AW = 21,
  parameter int unsigned DW = 8
) (
  input  logic          CLK96,
  input  logic          RESET96,
  input  logic          REQ0_CS,
  input  logic [AW-1:0] REQ0_ADDR,
  output logic          REQ0_OK,
  output logic [DW-1:0] REQ0_DOUT,
  input  logic          REQ1_CS,
  input  logic [AW-1:0] REQ1_ADDR,
  output logic          REQ1_OK,
  output logic [DW-1:0] REQ1_DOUT,
  output logic          SD_CS,
  output logic [AW-1:0] SD_ADDR,
  input  logic          SD_OK,
  input  logic [DW-1:0] SD_DOUT
);

  typedef enum logic [1:0] {StIdle, StWait0, StWait1} state_e;

  state_e        state_q, state_d;
  logic          first_q, first_d;      // first cycle of a wait: SD_OK may be stale
  logic          sd_cs_q, sd_cs_d;
  logic [AW-1:0] sd_addr_q, sd_addr_d;
  logic          last_q, last_d;        // channel served most recently
  logic [AW-1:0] tag0_q, tag1_q;
  logic [DW-1:0] data0_q, data1_q;
  logic          valid0_q, valid1_q;
  logic          cap0, cap1;
  logic          pend0, pend1;

  assign REQ0_OK   = REQ0_CS & valid0_q & (REQ0_ADDR == tag0_q);
  assign REQ1_OK   = REQ1_CS & valid1_q & (REQ1_ADDR == tag1_q);
  assign REQ0_DOUT = data0_q;
  assign REQ1_DOUT = data1_q;
  assign pend0     = REQ0_CS & ~REQ0_OK;
  assign pend1     = REQ1_CS & ~REQ1_OK;
  assign SD_CS     = sd_cs_q;
  assign SD_ADDR   = sd_addr_q;

  always_comb begin
    state_d   = state_q;
    first_d   = 1'b0;
    sd_cs_d   = sd_cs_q;
    sd_addr_d = sd_addr_q;
    last_d    = last_q;
    cap0      = 1'b0;
    cap1      = 1'b0;
    case (state_q)
      StIdle: begin
        sd_cs_d = 1'b0;
        // Channel 0 wins when alone, or on a tie if channel 1 was served last.
        if (pend0 && (!pend1 || last_q)) begin
          state_d   = StWait0;
          sd_cs_d   = 1'b1;
          sd_addr_d = REQ0_ADDR;
          first_d   = 1'b1;
        end else if (pend1) begin
          state_d   = StWait1;
          sd_cs_d   = 1'b1;
          sd_addr_d = REQ1_ADDR;
          first_d   = 1'b1;
        end
      end
      StWait0: begin
        if (!first_q && SD_OK) begin
          cap0    = 1'b1;
          last_d  = 1'b0;
          sd_cs_d = 1'b0;
          state_d = StIdle;
        end
      end
      StWait1: begin
        if (!first_q && SD_OK) begin
          cap1    = 1'b1;
          last_d  = 1'b1;
          sd_cs_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        sd_cs_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      state_q   <= StIdle;
      first_q   <= 1'b0;
      sd_cs_q   <= 1'b0;
      sd_addr_q <= '0;
      last_q    <= 1'b1;
      tag0_q    <= '0;
      tag1_q    <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
      valid0_q  <= 1'b0;
      valid1_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      sd_cs_q   <= sd_cs_d;
      sd_addr_q <= sd_addr_d;
      last_q    <= last_d;
      // The stored tag is the address actually fetched, not the live request.
      if (cap0) begin
        tag0_q   <= sd_addr_q;
        data0_q  <= SD_DOUT;
        valid0_q <= 1'b1;
      end
      if (cap1) begin
        tag1_q   <= sd_addr_q;
        data1_q  <= SD_DOUT;
        valid1_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_batrider_pcm_arbiter.sv
// Directed self-checking bench for batrider_pcm_arbiter.
module tb_batrider_pcm_arbiter;
  localparam int AW = 21;
  localparam int DW = 8;

  logic          CLK96, RESET96;
  logic          REQ0_CS, REQ1_CS, REQ0_OK, REQ1_OK;
  logic [AW-1:0] REQ0_ADDR, REQ1_ADDR, SD_ADDR;
  logic [DW-1:0] REQ0_DOUT, REQ1_DOUT, SD_DOUT;
  logic          SD_CS, SD_OK;

  int pass_cnt = 0;
  int total_cnt = 0;

  batrider_pcm_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK96(CLK96), .RESET96(RESET96),
    .REQ0_CS(REQ0_CS), .REQ0_ADDR(REQ0_ADDR), .REQ0_OK(REQ0_OK), .REQ0_DOUT(REQ0_DOUT),
    .REQ1_CS(REQ1_CS), .REQ1_ADDR(REQ1_ADDR), .REQ1_OK(REQ1_OK), .REQ1_DOUT(REQ1_DOUT),
    .SD_CS(SD_CS), .SD_ADDR(SD_ADDR), .SD_OK(SD_OK), .SD_DOUT(SD_DOUT)
  );

  initial CLK96 = 1'b0;
  always #5 CLK96 = ~CLK96;

  // Advance to 1 time unit after the next rising edge.
  task automatic nxt();
    @(posedge CLK96);
    #1;
  endtask

  task automatic do_reset();
    REQ0_CS = 0; REQ1_CS = 0; REQ0_ADDR = '0; REQ1_ADDR = '0;
    SD_OK = 0; SD_DOUT = '0; RESET96 = 1;
    nxt();
    nxt();
    RESET96 = 0;
  endtask

  task automatic test_reset();
    do_reset();
    REQ0_CS = 1; REQ0_ADDR = '0;  // tag resets to 0, so only valid blocks a hit
    #1;
    total_cnt++; if (SD_CS !== 1'b0) $display("FAIL rst_sd_cs got=%b want=0", SD_CS); else pass_cnt++;
    total_cnt++; if (SD_ADDR !== '0) $display("FAIL rst_sd_addr got=%h want=0", SD_ADDR); else pass_cnt++;
    total_cnt++; if (REQ0_OK !== 1'b0) $display("FAIL rst_ok0 got=%b want=0", REQ0_OK); else pass_cnt++;
    total_cnt++; if (REQ0_DOUT !== 8'h00) $display("FAIL rst_dout0 got=%h want=00", REQ0_DOUT); else pass_cnt++;
    total_cnt++; if (REQ1_DOUT !== 8'h00) $display("FAIL rst_dout1 got=%h want=00", REQ1_DOUT); else pass_cnt++;
    REQ0_CS = 0;
  endtask

  task automatic test_single_miss();
    do_reset();
    // cycle 0: miss; SD_OK already high with junk data (must be ignored as stale)
    REQ0_CS = 1; REQ0_ADDR = 21'h01234; SD_OK = 1; SD_DOUT = 8'h77;
    #1;
    total_cnt++; if (REQ0_OK !== 1'b0) $display("FAIL miss_c0_ok got=%b want=0", REQ0_OK); else pass_cnt++;
    total_cnt++; if (SD_CS !== 1'b0) $display("FAIL miss_c0_cs got=%b want=0", SD_CS); else pass_cnt++;
    nxt();  // cycle 1
    #1;
    total_cnt++; if (SD_CS !== 1'b1) $display("FAIL miss_c1_cs got=%b want=1", SD_CS); else pass_cnt++;
    total_cnt++; if (SD_ADDR !== 21'h01234) $display("FAIL miss_c1_addr got=%h want=01234", SD_ADDR); else pass_cnt++;
    nxt();  // cycle 2
    SD_DOUT = 8'h5A;
    #1;
    total_cnt++; if (REQ0_OK !== 1'b0) $display("FAIL miss_c2_stale_ok got=%b want=0", REQ0_OK); else pass_cnt++;
    total_cnt++; if (SD_CS !== 1'b1) $display("FAIL miss_c2_cs got=%b want=1", SD_CS); else pass_cnt++;
    nxt();  // cycle 3
    SD_OK = 0;
    #1;
    total_cnt++; if (REQ0_OK !== 1'b1) $display("FAIL miss_c3_ok got=%b want=1", REQ0_OK); else pass_cnt++;
    total_cnt++; if (REQ0_DOUT !== 8'h5A) $display("FAIL miss_c3_dout got=%h want=5a", REQ0_DOUT); else pass_cnt++;
    total_cnt++; if (SD_CS !== 1'b0) $display("FAIL miss_c3_cs got=%b want=0", SD_CS); else pass_cnt++;
    REQ0_CS = 0;
  endtask

  task automatic test_simultaneous_and_hit();
    do_reset();
    REQ0_CS = 1; REQ0_ADDR = 21'h00010; REQ1_CS = 1; REQ1_ADDR = 21'h100020;
    SD_OK = 1; SD_DOUT = 8'h11;
    nxt();  // cycle 1
    #1;
    total_cnt++; if (SD_ADDR !== 21'h00010) $display("FAIL sim_first_addr got=%h want=00010", SD_ADDR); else pass_cnt++;
    nxt();  // cycle 2
    nxt();  // cycle 3
    #1;
    total_cnt++; if (SD_CS !== 1'b0) $display("FAIL sim_gap_cs got=%b want=0", SD_CS); else pass_cnt++;
    total_cnt++; if (REQ0_OK !== 1'b1) $display("FAIL sim_ok0 got=%b want=1", REQ0_OK); else pass_cnt++;
    nxt();  // cycle 4
    SD_DOUT = 8'h22;
    #1;
    total_cnt++; if (SD_CS !== 1'b1) $display("FAIL sim_second_cs got=%b want=1", SD_CS); else pass_cnt++;
    total_cnt++; if (SD_ADDR !== 21'h100020) $display("FAIL sim_second_addr got=%h want=100020", SD_ADDR); else pass_cnt++;
    nxt();  // cycle 5
    nxt();  // cycle 6
    SD_OK = 0;
    #1;
    total_cnt++; if (REQ1_OK !== 1'b1) $display("FAIL sim_ok1 got=%b want=1", REQ1_OK); else pass_cnt++;
    total_cnt++; if (REQ1_DOUT !== 8'h22) $display("FAIL sim_dout1 got=%h want=22", REQ1_DOUT); else pass_cnt++;
    total_cnt++; if (REQ0_OK !== 1'b1) $display("FAIL sim_ok0_kept got=%b want=1", REQ0_OK); else pass_cnt++;
    total_cnt++; if (REQ0_DOUT !== 8'h11) $display("FAIL sim_dout0_kept got=%h want=11", REQ0_DOUT); else pass_cnt++;
    total_cnt++; if (SD_CS !== 1'b0) $display("FAIL sim_c6_cs got=%b want=0", SD_CS); else pass_cnt++;
    nxt();  // cycle 7: repeated address is a pure hit
    #1;
    total_cnt++; if (REQ1_OK !== 1'b1) $display("FAIL hit_ok1 got=%b want=1", REQ1_OK); else pass_cnt++;
    total_cnt++; if (SD_CS !== 1'b0) $display("FAIL hit_cs got=%b want=0", SD_CS); else pass_cnt++;
    REQ0_CS = 0; REQ1_CS = 0;
  endtask

  task automatic test_addr_change();
    do_reset();
    REQ0_CS = 1; REQ0_ADDR = 21'h00100;
    nxt();  // cycle 1: first wait cycle
    REQ0_ADDR = 21'h00101;
    nxt();  // cycle 2
    SD_OK = 1; SD_DOUT = 8'h33;
    #1;
    total_cnt++; if (SD_ADDR !== 21'h00100) $display("FAIL chg_addr_held got=%h want=00100", SD_ADDR); else pass_cnt++;
    nxt();  // cycle 3: back in idle, stored tag is 0x100
    SD_OK = 0;
    #1;
    total_cnt++; if (REQ0_OK !== 1'b0) $display("FAIL chg_ok_after got=%b want=0", REQ0_OK); else pass_cnt++;
    total_cnt++; if (SD_CS !== 1'b0) $display("FAIL chg_gap_cs got=%b want=0", SD_CS); else pass_cnt++;
    nxt();  // cycle 4: second transaction for 0x101
    #1;
    total_cnt++; if (SD_CS !== 1'b1) $display("FAIL chg_second_cs got=%b want=1", SD_CS); else pass_cnt++;
    total_cnt++; if (SD_ADDR !== 21'h00101) $display("FAIL chg_second_addr got=%h want=00101", SD_ADDR); else pass_cnt++;
    REQ0_ADDR = 21'h00100;  // hit on the old tag while waiting
    #1;
    total_cnt++; if (REQ0_OK !== 1'b1) $display("FAIL chg_hit_in_wait got=%b want=1", REQ0_OK); else pass_cnt++;
    total_cnt++; if (REQ0_DOUT !== 8'h33) $display("FAIL chg_hit_dout got=%h want=33", REQ0_DOUT); else pass_cnt++;
    nxt();  // cycle 5
    REQ0_ADDR = 21'h00101; SD_OK = 1; SD_DOUT = 8'h44;
    nxt();  // cycle 6
    SD_OK = 0;
    #1;
    total_cnt++; if (REQ0_OK !== 1'b1) $display("FAIL chg_fill2_ok got=%b want=1", REQ0_OK); else pass_cnt++;
    total_cnt++; if (REQ0_DOUT !== 8'h44) $display("FAIL chg_fill2_dout got=%h want=44", REQ0_DOUT); else pass_cnt++;
    REQ0_CS = 0;
  endtask

  // Relies on channel 0 holding tag 0x101 / data 0x44 from test_addr_change.
  task automatic test_reset_mid_wait();
    REQ1_CS = 1; REQ1_ADDR = 21'h00055; SD_OK = 0;
    nxt();  // cycle 1: WAIT1
    REQ0_CS = 1; REQ0_ADDR = 21'h00101;
    #1;
    total_cnt++; if (SD_CS !== 1'b1) $display("FAIL rw_wait_cs got=%b want=1", SD_CS); else pass_cnt++;
    total_cnt++; if (REQ0_OK !== 1'b1) $display("FAIL rw_pre_ok0 got=%b want=1", REQ0_OK); else pass_cnt++;
    RESET96 = 1; REQ0_CS = 0;
    nxt();  // cycle 2
    RESET96 = 0; REQ1_CS = 0; REQ0_CS = 1;
    #1;
    total_cnt++; if (SD_CS !== 1'b0) $display("FAIL rw_cs got=%b want=0", SD_CS); else pass_cnt++;
    total_cnt++; if (SD_ADDR !== '0) $display("FAIL rw_addr got=%h want=0", SD_ADDR); else pass_cnt++;
    total_cnt++; if (REQ0_OK !== 1'b0) $display("FAIL rw_ok0 got=%b want=0", REQ0_OK); else pass_cnt++;
    REQ0_CS = 0; SD_OK = 1; SD_DOUT = 8'h99;
    nxt();  // cycle 3: the late SD_OK must have been ignored
    SD_OK = 0; REQ1_CS = 1; REQ1_ADDR = '0;
    #1;
    total_cnt++; if (SD_CS !== 1'b0) $display("FAIL rw_late_cs got=%b want=0", SD_CS); else pass_cnt++;
    total_cnt++; if (REQ1_OK !== 1'b0) $display("FAIL rw_ok1_tag0 got=%b want=0", REQ1_OK); else pass_cnt++;
    REQ1_ADDR = 21'h00055;
    #1;
    total_cnt++; if (REQ1_OK !== 1'b0) $display("FAIL rw_ok1_55 got=%b want=0", REQ1_OK); else pass_cnt++;
    total_cnt++; if (REQ1_DOUT !== 8'h00) $display("FAIL rw_dout1 got=%h want=00", REQ1_DOUT); else pass_cnt++;
    REQ1_CS = 0;
  endtask

  task automatic test_long_wait();
    do_reset();
    REQ1_CS = 1; REQ1_ADDR = 21'h0ABCD;
    for (int i = 0; i < 20; i++) nxt();
    #1;
    total_cnt++; if (SD_CS !== 1'b1) $display("FAIL long_cs got=%b want=1", SD_CS); else pass_cnt++;
    total_cnt++; if (SD_ADDR !== 21'h0ABCD) $display("FAIL long_addr got=%h want=0abcd", SD_ADDR); else pass_cnt++;
    SD_OK = 1; SD_DOUT = 8'hC3;
    nxt();
    SD_OK = 0;
    #1;
    total_cnt++; if (REQ1_OK !== 1'b1) $display("FAIL long_ok1 got=%b want=1", REQ1_OK); else pass_cnt++;
    total_cnt++; if (REQ1_DOUT !== 8'hC3) $display("FAIL long_dout1 got=%h want=c3", REQ1_DOUT); else pass_cnt++;
    REQ1_CS = 0;
  endtask

  task automatic test_back_to_back();
    int   grants;
    logic prev_cs;
    logic ch [4];
    do_reset();
    grants = 0; prev_cs = 0;
    SD_OK = 1; SD_DOUT = 8'h5C;
    for (int i = 0; i < 40 && grants < 4; i++) begin
      // Addresses move every cycle so both channels miss continuously.
      REQ0_CS = 1; REQ0_ADDR = 21'h00300 | AW'(i);
      REQ1_CS = 1; REQ1_ADDR = 21'h00200 | AW'(i);
      #1;
      if (SD_CS && !prev_cs) begin
        ch[grants] = (SD_ADDR[9:8] == 2'b11) ? 1'b0 : 1'b1;
        grants++;
      end
      prev_cs = SD_CS;
      nxt();
    end
    total_cnt++; if (grants !== 4) $display("FAIL rr_grant_count got=%0d want=4", grants); else pass_cnt++;
    if (grants == 4) begin
      for (int k = 0; k < 4; k++) begin
        total_cnt++;
        if (ch[k] !== k[0]) $display("FAIL rr_grant%0d got=ch%0d want=ch%0d", k, ch[k], k[0]);
        else pass_cnt++;
      end
    end
    REQ0_CS = 0; REQ1_CS = 0; SD_OK = 0;
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_simultaneous_and_hit();
    test_addr_change();
    test_reset_mid_wait();
    test_long_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
